// File: rtl/float_add_rq_81_pkg.sv
// Shared float field layout and flag encoding for the adder result-capture stage.
package fadd_pkg_81;

    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;

    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    localparam int FLAG_W      = 4;
    localparam int FLAG_NAN    = 3;
    localparam int FLAG_INF    = 2;
    localparam int FLAG_ZERO   = 1;
    localparam int FLAG_DENORM = 0;

    // Class of a single-precision word; exactly one bit is set for the special classes.
    function automatic logic [FLAG_W-1:0] classify(input logic [31:0] word);
        logic [EXP_MSB-EXP_LSB:0] exp_f;
        logic [MANT_MSB:0]        mant_f;
        logic [FLAG_W-1:0]        flags;
        exp_f  = word[EXP_MSB:EXP_LSB];
        mant_f = word[MANT_MSB:0];
        flags  = '0;
        flags[FLAG_NAN]    = (exp_f == EXP_ALL_ONES) && (mant_f != '0);
        flags[FLAG_INF]    = (exp_f == EXP_ALL_ONES) && (mant_f == '0);
        flags[FLAG_ZERO]   = (exp_f == '0) && (mant_f == '0);
        flags[FLAG_DENORM] = (exp_f == '0) && (mant_f != '0);
        return flags;
    endfunction

endpackage

// File: rtl/float_add_rq_81_fifo.sv
// Synchronous FIFO with occupancy count and wrapping pointers; push into a full FIFO is
// refused unless a pop frees the slot on the same edge.
module fadd_rq_fifo_81 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 5
) (
    input  logic             clk81,
    input  logic             reset_81,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [WIDTH-1:0] last_pop;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign ovf     = wr_en && full && !do_pop;

    // Once drained, the head keeps showing the most recently popped word.
    assign rd_data = empty ? last_pop : mem[rd_ptr];

    always_ff @(posedge clk81) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk81 or posedge reset_81) begin
        if (reset_81) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            last_pop <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                last_pop <= mem[rd_ptr];
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/float_add_rq_81.sv
// Result-capture queue behind the fixed-latency float adder, with credit-based issue_ready.
// Optional per-entry class flags on out_flags when FADD_RQ_FLAGS_EN is defined.
module float_add_rq_81
    import fadd_pkg_81::*;
#(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4,
    parameter int CW      = 5
) (
    input  logic          clk81,
    input  logic          reset_81,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [31:0]   add_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [CW-1:0] occupancy,
    output logic          err_ovf
`ifdef FADD_RQ_FLAGS_EN
    ,
    output logic [FLAG_W-1:0] out_flags
`endif
);

    logic [LATENCY-1:0] valid_pipe;
    logic               issue_fire;
    logic               capture;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic               data_ovf;
    logic               any_ovf;

    assign issue_fire = issue_valid && issue_ready;
    assign capture    = valid_pipe[LATENCY-1];

    // Tags accepted issues so each result is captured exactly when the adder presents it.
    always_ff @(posedge clk81 or posedge reset_81) begin
        if (reset_81) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= issue_fire;
            for (int i = 1; i < LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CW'(valid_pipe[i]);
        end
    end

    // Credits cover both queued and in-flight results, since the adder cannot be stalled.
    assign occupancy   = fifo_count + inflight;
    assign issue_ready = (occupancy < CW'(DEPTH));
    assign out_valid   = !fifo_empty;

    fadd_rq_fifo_81 #(
        .WIDTH (32),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_data_fifo (
        .clk81    (clk81),
        .reset_81 (reset_81),
        .wr_en    (capture),
        .wr_data  (add_result),
        .rd_en    (out_ready),
        .rd_data  (out_data),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .ovf      (data_ovf)
    );

`ifdef FADD_RQ_FLAGS_EN
    logic [CW-1:0] flag_count_unused;
    logic          flag_empty_unused;
    logic          flag_ovf;

    fadd_rq_fifo_81 #(
        .WIDTH (FLAG_W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_flag_fifo (
        .clk81    (clk81),
        .reset_81 (reset_81),
        .wr_en    (capture),
        .wr_data  (classify(add_result)),
        .rd_en    (out_ready),
        .rd_data  (out_flags),
        .count    (flag_count_unused),
        .empty    (flag_empty_unused),
        .ovf      (flag_ovf)
    );

    assign any_ovf = data_ovf || flag_ovf;
`else
    assign any_ovf = data_ovf;
`endif

    always_ff @(posedge clk81 or posedge reset_81) begin
        if (reset_81) begin
            err_ovf <= 1'b0;
        end else if (any_ovf) begin
            err_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_float_add_rq_81.sv
// Bench for float_add_rq_81: directed vector table, reset and overflow sequences, then random traffic vs a queue model.
module tb_float_add_rq_81;

    localparam int LATENCY = 1;
    localparam int DEPTH   = 4;
    localparam int CW      = 5;

    typedef struct {
        logic [31:0] data;
        int          due;
    } inflight_t;

    typedef struct {
        logic        iv;
        logic [31:0] sum;
        logic        ordy;
        logic        exp_valid;
        logic [31:0] exp_data;
        int          exp_occ;
        logic        exp_ready;
    } vec_t;

    logic          clk81 = 1'b0;
    logic          reset_81;
    logic          issue_valid;
    logic          issue_ready;
    logic [31:0]   sum_in;
    logic [31:0]   add_result;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [CW-1:0] occupancy;
    logic          err_ovf;
`ifdef FADD_RQ_FLAGS_EN
    logic [3:0]    out_flags;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        ovf_exp = 1'b0;
    logic [31:0] fifo_q[$];
    inflight_t   infl_q[$];
    vec_t        vecs[16];
    logic [31:0] add_pipe [LATENCY];

    float_add_rq_81 #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH),
        .CW      (CW)
    ) dut (
        .clk81       (clk81),
        .reset_81    (reset_81),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .add_result  (add_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .err_ovf     (err_ovf)
`ifdef FADD_RQ_FLAGS_EN
        ,
        .out_flags   (out_flags)
`endif
    );

    always #5 clk81 = ~clk81;

    // Stand-in for the adder: sum_in plays the role of the sum of the operands on its inputs.
    always @(posedge clk81 or posedge reset_81) begin
        if (reset_81) begin
            for (int i = 0; i < LATENCY; i++) add_pipe[i] <= '0;
        end else begin
            add_pipe[0] <= sum_in;
            for (int i = 1; i < LATENCY; i++) add_pipe[i] <= add_pipe[i-1];
        end
    end
    assign add_result = add_pipe[LATENCY-1];

    function automatic logic [3:0] flagsOf(input logic [31:0] w);
        logic nan_b, inf_b, zero_b, den_b;
        nan_b  = (w[30:23] == 8'hFF) && (w[22:0] != 0);
        inf_b  = (w[30:23] == 8'hFF) && (w[22:0] == 0);
        zero_b = (w[30:23] == 8'h00) && (w[22:0] == 0);
        den_b  = (w[30:23] == 8'h00) && (w[22:0] != 0);
        return {nan_b, inf_b, zero_b, den_b};
    endfunction

    function automatic logic [31:0] pickWord();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[30:23] = 8'hFF;
            1: w[30:23] = 8'h00;
            2: w[22:0]  = '0;
            default: ;
        endcase
        return w;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic modelReset();
        fifo_q.delete();
        infl_q.delete();
        ovf_exp = 1'b0;
    endtask

    // One clock edge of the queue model: pop, then capture due results, then accept an issue.
    task automatic modelStep();
        int   occ_pre;
        logic rdy_pre;
        occ_pre = fifo_q.size() + infl_q.size();
        rdy_pre = (occ_pre < DEPTH);
        if (out_ready && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (infl_q.size() > 0 && infl_q[0].due == cyc) begin
            if (fifo_q.size() < DEPTH) fifo_q.push_back(infl_q[0].data);
            else ovf_exp = 1'b1;
            void'(infl_q.pop_front());
        end
        if (issue_valid && rdy_pre) infl_q.push_back('{sum_in, cyc + LATENCY});
        cyc++;
    endtask

    task automatic checkOutput();
        int exp_occ;
        exp_occ = fifo_q.size() + infl_q.size();
        checkVal("out_valid", 32'(out_valid), 32'(fifo_q.size() > 0));
        if (fifo_q.size() > 0) checkVal("out_data", out_data, fifo_q[0]);
        checkVal("occupancy", 32'(occupancy), 32'(exp_occ));
        checkVal("issue_ready", 32'(issue_ready), 32'(exp_occ < DEPTH));
        checkVal("err_ovf", 32'(err_ovf), 32'(ovf_exp));
`ifdef FADD_RQ_FLAGS_EN
        if (fifo_q.size() > 0) checkVal("out_flags", 32'(out_flags), 32'(flagsOf(fifo_q[0])));
`endif
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] s, input logic ordy);
        issue_valid = iv;
        sum_in      = s;
        out_ready   = ordy;
        @(posedge clk81);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic checkVec(input int idx);
        checkVal($sformatf("vec%0d.out_valid", idx), 32'(out_valid), 32'(vecs[idx].exp_valid));
        if (vecs[idx].exp_valid) checkVal($sformatf("vec%0d.out_data", idx), out_data, vecs[idx].exp_data);
        checkVal($sformatf("vec%0d.occupancy", idx), 32'(occupancy), 32'(vecs[idx].exp_occ));
        checkVal($sformatf("vec%0d.issue_ready", idx), 32'(issue_ready), 32'(vecs[idx].exp_ready));
    endtask

    task automatic pulseReset();
        #1 reset_81 = 1'b1;
        #1;
        modelReset();
        checkVal("rst.out_valid", 32'(out_valid), 32'd0);
        checkVal("rst.occupancy", 32'(occupancy), 32'd0);
        checkVal("rst.issue_ready", 32'(issue_ready), 32'd1);
        checkVal("rst.err_ovf", 32'(err_ovf), 32'd0);
        checkVal("rst.out_data", out_data, 32'd0);
`ifdef FADD_RQ_FLAGS_EN
        checkVal("rst.out_flags", 32'(out_flags), 32'd0);
`endif
        #1 reset_81 = 1'b0;
    endtask

    initial begin
        // Hand-derived expectations for LATENCY=1, DEPTH=4; row 0 carries 1.5+2.25.
        vecs[0]  = '{1'b1, 32'h40700000, 1'b1, 1'b0, 32'h0,        0 + 1, 1'b1};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h40700000, 1,     1'b1};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0,     1'b1};
        vecs[3]  = '{1'b1, 32'hA0000001, 1'b0, 1'b0, 32'h0,        1,     1'b1};
        vecs[4]  = '{1'b1, 32'hA0000002, 1'b0, 1'b1, 32'hA0000001, 2,     1'b1};
        vecs[5]  = '{1'b1, 32'hA0000003, 1'b0, 1'b1, 32'hA0000001, 3,     1'b1};
        vecs[6]  = '{1'b1, 32'hA0000004, 1'b0, 1'b1, 32'hA0000001, 4,     1'b0};
        vecs[7]  = '{1'b1, 32'hA0000005, 1'b0, 1'b1, 32'hA0000001, 4,     1'b0};
        vecs[8]  = '{1'b1, 32'hA0000006, 1'b0, 1'b1, 32'hA0000001, 4,     1'b0};
        vecs[9]  = '{1'b1, 32'hB0000001, 1'b1, 1'b1, 32'hA0000002, 3,     1'b1};
        vecs[10] = '{1'b1, 32'hB0000002, 1'b0, 1'b1, 32'hA0000002, 4,     1'b0};
        vecs[11] = '{1'b1, 32'hB0000003, 1'b1, 1'b1, 32'hA0000003, 3,     1'b1};
        vecs[12] = '{1'b1, 32'hB0000004, 1'b1, 1'b1, 32'hA0000004, 3,     1'b1};
        vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hB0000002, 2,     1'b1};
        vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hB0000004, 1,     1'b1};
        vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0,     1'b1};

        issue_valid = 1'b0;
        sum_in      = '0;
        out_ready   = 1'b0;
        reset_81    = 1'b1;
        #12;
        checkVal("init.out_valid", 32'(out_valid), 32'd0);
        checkVal("init.out_data", out_data, 32'd0);
        checkVal("init.occupancy", 32'(occupancy), 32'd0);
        checkVal("init.issue_ready", 32'(issue_ready), 32'd1);
        checkVal("init.err_ovf", 32'(err_ovf), 32'd0);
        reset_81 = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].sum, vecs[i].ordy);
            checkVec(i);
        end

        $display("[TB] reset with two queued and one in flight");
        applyStimulus(1'b1, 32'hC0000001, 1'b0);
        applyStimulus(1'b1, 32'hC0000002, 1'b0);
        applyStimulus(1'b1, 32'hC0000003, 1'b0);
        checkVal("pre_rst.occupancy", 32'(occupancy), 32'd3);
        issue_valid = 1'b0;
        pulseReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("[TB] capture forced into a full queue");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hD0000001 + 32'(i), 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        force dut.valid_pipe = '1;
        @(posedge clk81);
        #1;
        checkVal("bd.err_ovf", 32'(err_ovf), 32'd1);
        release dut.valid_pipe;
        @(posedge clk81);
        cyc += 2;
        ovf_exp = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkVal("bd.contents", out_data, 32'hD0000001 + 32'(i));
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        checkVal("bd.sticky", 32'(err_ovf), 32'd1);
        pulseReset();

`ifdef FADD_RQ_FLAGS_EN
        $display("[TB] flag classes");
        begin
            logic [31:0] fw [4];
            logic [3:0]  fe [4];
            fw = '{32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h00000001};
            fe = '{4'b0100, 4'b1000, 4'b0010, 4'b0001};
            for (int i = 0; i < 4; i++) applyStimulus(1'b1, fw[i], 1'b0);
            applyStimulus(1'b0, 32'h0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                checkVal("flags_dir", 32'(out_flags), 32'(fe[i]));
                applyStimulus(1'b0, 32'h0, 1'b1);
            end
        end
`endif

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            logic ordy;
            if (i < 300) ordy = ($urandom_range(0, 9) < 3);
            else ordy = ($urandom_range(0, 9) < 8);
            applyStimulus($urandom_range(0, 9) < 7, pickWord(), ordy);
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
